// File: rtl/mysopc_led_pkg.sv
// Shared constants for the LED dimmer: register map, CTRL bit positions, PRESCALE default.
// Also the CTRL register layout and a STATUS word packer used by the top.
package mysopc_led_pkg;

   localparam int unsigned PRESCALE_DEFAULT = 50;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_BLINK_BIT = 1;

   // Field order mirrors the CTRL bit positions so the struct reads back as-is.
   typedef struct packed {
      logic blink_en;
      logic enable;
   } ctrl_t;

   function automatic logic [31:0] status_word(logic [7:0] pwm_cnt, logic blink_phase);
      return {16'h0000, pwm_cnt, 7'h00, blink_phase};
   endfunction

endpackage

// File: rtl/mysopc_led_dimmer_if.sv
// Avalon-MM slave register port of the LED dimmer (zero wait states, no waitrequest).
interface mysopc_led_dimmer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mysopc_led_timebase.sv
// PWM timebase: prescaler producing a tick every PRESCALE clocks and an 8-bit pwm_cnt.
// frame_end is the tick on which pwm_cnt wraps 255->0; everything is held at 0 while disabled.
module mysopc_led_timebase #(
   parameter int unsigned PRESCALE = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_i,
   output logic       tick_o,
   output logic       frame_end_o,
   output logic [7:0] pwm_cnt_o
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic [15:0] presc_q, presc_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;

   assign tick_o      = enable_i && (presc_q == PRESC_MAX);
   assign frame_end_o = tick_o && (pwm_cnt_q == 8'hFF);
   assign pwm_cnt_o   = pwm_cnt_q;

   always_comb begin
      presc_d   = presc_q;
      pwm_cnt_d = pwm_cnt_q;
      if (!enable_i) begin
         presc_d   = '0;
         pwm_cnt_d = '0;
      end else if (tick_o) begin
         presc_d   = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
         presc_d   = presc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

endmodule

// File: rtl/mysopc_led_dimmer.sv
// Avalon-MM controlled LED dimmer: PWM duty dimming plus optional blinking of an 8-bit pattern.
// led_out is registered, one cycle behind pattern_in; register reads are combinational.
module mysopc_led_dimmer
   import mysopc_led_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   mysopc_led_dimmer_if.slave         avs,
   input  logic [7:0]                 pattern_in,
   output logic [7:0]                 led_out
);

   ctrl_t       ctrl_q;
   logic [7:0]  duty_q;
   logic [15:0] period_q;
   logic [15:0] frame_q, frame_d;
   logic        phase_q, phase_d;
   logic [7:0]  led_q, led_d;

   logic        wr_en, wr_blink;
   logic        tick, frame_end, pwm_on;
   logic [7:0]  pwm_cnt;
   logic        unused_bits;

   assign wr_en       = avs.chipselect && !avs.write_n;
   assign wr_blink    = wr_en && (avs.address == ADDR_BLINK);
   assign unused_bits = ^{avs.writedata[31:16], tick};

   mysopc_led_timebase #(.PRESCALE(PRESCALE)) u_timebase (
      .clk         (clk),
      .reset       (reset),
      .enable_i    (ctrl_q.enable),
      .tick_o      (tick),
      .frame_end_o (frame_end),
      .pwm_cnt_o   (pwm_cnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q   <= '0;
         duty_q   <= '0;
         period_q <= '0;
      end else if (wr_en) begin
         case (avs.address)
            ADDR_CTRL: begin
               ctrl_q.enable   <= avs.writedata[CTRL_EN_BIT];
               ctrl_q.blink_en <= avs.writedata[CTRL_BLINK_BIT];
            end
            ADDR_DUTY:  duty_q   <= avs.writedata[7:0];
            ADDR_BLINK: period_q <= avs.writedata[15:0];
            default: ;
         endcase
      end
   end

   // A BLINK_PERIOD write restarts the blink sequence in the lit phase.
   always_comb begin
      frame_d = frame_q;
      phase_d = phase_q;
      if (wr_blink || !ctrl_q.enable || (period_q == 16'd0)) begin
         frame_d = '0;
         phase_d = 1'b1;
      end else if (frame_end) begin
         if (frame_q == period_q - 16'd1) begin
            frame_d = '0;
            phase_d = !phase_q;
         end else begin
            frame_d = frame_q + 16'd1;
         end
      end
   end

   assign pwm_on = (duty_q == 8'hFF) || (duty_q > pwm_cnt);
   assign led_d  = pattern_in & {8{ctrl_q.enable && pwm_on && (phase_q || !ctrl_q.blink_en)}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
         phase_q <= 1'b1;
         led_q   <= '0;
      end else begin
         frame_q <= frame_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign led_out = led_q;

   always_comb begin
      avs.readdata = '0;
      case (avs.address)
         ADDR_CTRL:   avs.readdata = {30'h0, ctrl_q};
         ADDR_DUTY:   avs.readdata = {24'h0, duty_q};
         ADDR_BLINK:  avs.readdata = {16'h0, period_q};
         ADDR_STATUS: avs.readdata = status_word(pwm_cnt, phase_q);
         default:     avs.readdata = '0;
      endcase
   end

endmodule

// File: doc/mysopc_led_dimmer.md
MYSOPC_LED_DIMMER -- requirements
Module: mysopc_led_dimmer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50: clk cycles per PWM tick, legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port address, input, 2: Avalon-MM slave register select.
REQ-005 SHALL have port chipselect, input, 1: Avalon-MM slave select.
REQ-006 SHALL have port write_n, input, 1: Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata, input, 32: Avalon-MM write data.
REQ-008 SHALL have port readdata, output, 32: Avalon-MM read data, combinational from address, zero wait states.
REQ-009 SHALL have port pattern_in, input, 8: LED on/off pattern taken from the LED PIO out_port in the same clock domain.
REQ-010 SHALL have port led_out, output, 8: registered, dimmed and blinked LED drive.

Function
REQ-011 SHALL decode a write as chipselect=1 and write_n=0, committing on that clock edge.
REQ-012 SHALL map address 0 to CTRL: bit0 enable, bit1 blink_en, read/write, other bits read 0.
REQ-013 SHALL map address 1 to DUTY[7:0], read/write.
REQ-014 SHALL map address 2 to BLINK_PERIOD[15:0], counted in PWM frames, read/write.
REQ-015 SHALL map address 3 to STATUS, read-only, writes ignored: bit0 blink_phase, bits[15:8] pwm_cnt.
REQ-016 SHALL zero-extend every readdata field to 32 bits.
REQ-017 SHALL run a prescaler counting 0..PRESCALE-1 while enable=1, emitting a one-cycle tick when the count is PRESCALE-1 and wrapping to 0.
REQ-018 SHALL advance the 8-bit pwm_cnt on each tick, wrapping 255->0.
REQ-019 SHALL define frame_end as the tick on which pwm_cnt wraps 255->0.
REQ-020 SHALL set pwm_on = (DUTY > pwm_cnt), except pwm_on = 1 whenever DUTY = 255.
REQ-021 SHALL count frames on frame_end; when the frame count equals BLINK_PERIOD-1 at a frame_end, it SHALL toggle blink_phase and clear the frame count.
REQ-022 SHALL hold blink_phase = 1 and the frame count at 0 while BLINK_PERIOD = 0.
REQ-023 SHALL, on any write to BLINK_PERIOD, clear the frame count and set blink_phase = 1 on the same edge.
REQ-024 SHALL, while enable = 0, hold the prescaler, pwm_cnt and frame count at 0 and blink_phase at 1.
REQ-025 SHALL register led_out <= pattern_in AND enable AND pwm_on AND (blink_phase OR NOT blink_en), per bit.
REQ-026 SHALL make a pattern_in change visible on led_out exactly 1 cycle later.
REQ-027 SHALL use new DUTY, CTRL and BLINK_PERIOD values in the cycle after the write.

Reset
REQ-028 SHALL, on reset=1, asynchronously clear CTRL, DUTY, BLINK_PERIOD, prescaler, pwm_cnt, frame count and led_out to 0, and set blink_phase to 1.
REQ-029 SHALL, if reset asserts mid-frame, abandon the frame; after release, counting restarts from 0 only once enable is written to 1.

Structure
REQ-030 SHALL place the register address constants, CTRL bit positions and the PRESCALE default in a shared package, mysopc_led_pkg.
REQ-031 SHALL implement the prescaler and pwm_cnt as one sub-module, mysopc_led_timebase, with outputs tick, frame_end and pwm_cnt.

Verification (bench uses PRESCALE = 2)
REQ-032 SHALL cover this case: after reset, read addresses 0..3 -> 0, 0, 0, 0x1; led_out = 0x00.
REQ-033 SHALL cover this case: pattern_in = 0xA5, CTRL = 1, DUTY = 128 -> led_out = 0xA5 for 256 clk cycles, then 0x00 for 256 clk cycles, repeating with a 512-cycle period.
REQ-034 SHALL cover this case: DUTY = 0 -> led_out stays 0x00; DUTY = 255 -> led_out continuously equals pattern_in.
REQ-035 SHALL cover this case: CTRL = 3, DUTY = 255, BLINK_PERIOD = 2, pattern_in = 0xFF -> led_out alternates 0xFF and 0x00 every 1024 clk cycles; STATUS bit0 tracks the alternation.
REQ-036 SHALL cover this case: while blinking, write BLINK_PERIOD = 0 -> led_out = 0xFF from the next cycle and STATUS bit0 = 1.
REQ-037 SHALL cover this case: assert reset mid-frame with pwm_cnt = 0x40 -> led_out = 0x00 and pwm_cnt = 0 immediately, without waiting for a clock edge.
